// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO controller with selectable standard or first-word-fall-through read mode.
// Latency: standard mode data_out is registered on the read-accept edge (1 cycle); FWFT mode shows the head entry combinationally.
// Backpressure: writes are refused while fifo_full and reads while fifo_empty; a refused request sets a sticky error flag.
//
// Ports:
//   clk, reset_n         single rising-edge clock, asynchronous active-low reset
//   clear                synchronous flush; beats wr_en/rd_en in the same cycle
//   wr_en, data_in       write request and data
//   rd_en, data_out      read request (pop) and read data
//   fifo_full/empty      occupancy == FIFO_DEPTH / == 0
//   fifo_almost_full     fill_count >= AF_THRESH
//   fifo_almost_empty    fill_count <= AE_THRESH
//   fill_count           registered occupancy, 0..FIFO_DEPTH
//   overflow/underflow   sticky: write while full / read while empty
module sync_fifo_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 8,
  parameter int FWFT       = 0,
  parameter int AF_THRESH  = FIFO_DEPTH - 2,
  parameter int AE_THRESH  = 2
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          clear,
  input  logic                          wr_en,
  input  logic [DATA_WIDTH-1:0]         data_in,
  input  logic                          rd_en,
  output logic [DATA_WIDTH-1:0]         data_out,
  output logic                          fifo_full,
  output logic                          fifo_empty,
  output logic                          fifo_almost_full,
  output logic                          fifo_almost_empty,
  output logic [$clog2(FIFO_DEPTH):0]   fill_count,
  output logic                          overflow,
  output logic                          underflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  // Illegal configurations are caught at elaboration rather than producing odd silicon.
  generate
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("sync_fifo_ctrl: FIFO_DEPTH must be a power of two and at least 2");
    end
    if (AF_THRESH < 0 || AF_THRESH > FIFO_DEPTH) begin : g_bad_af
      $error("sync_fifo_ctrl: AF_THRESH must lie in 0..FIFO_DEPTH");
    end
    if (AE_THRESH < 0 || AE_THRESH > FIFO_DEPTH) begin : g_bad_ae
      $error("sync_fifo_ctrl: AE_THRESH must lie in 0..FIFO_DEPTH");
    end
  endgenerate

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic                  wr_acc;
  logic                  rd_acc;

  // Acceptance is judged on the registered flags, so a full FIFO with both
  // requests pops but refuses the push, and an empty one pushes but refuses the pop.
  assign wr_acc = wr_en && !fifo_full;
  assign rd_acc = rd_en && !fifo_empty;

  assign fifo_full         = (fill_count == CW'(FIFO_DEPTH));
  assign fifo_empty        = (fill_count == '0);
  assign fifo_almost_full  = (fill_count >= CW'(AF_THRESH));
  assign fifo_almost_empty = (fill_count <= CW'(AE_THRESH));

  // Storage carries no reset; stale contents are never visible because
  // occupancy gates every read path.
  always_ff @(posedge clk) begin
    if (wr_acc && !clear && reset_n) begin
      mem[wr_ptr] <= data_in;
    end
  end

  // Pointers wrap naturally at AW bits since the depth is a power of two.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fill_count <= '0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
    end else if (clear) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fill_count <= '0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (rd_acc) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({wr_acc, rd_acc})
        2'b10:   fill_count <= fill_count + CW'(1);
        2'b01:   fill_count <= fill_count - CW'(1);
        default: fill_count <= fill_count;
      endcase
      if (wr_en && fifo_full) begin
        overflow <= 1'b1;
      end
      if (rd_en && fifo_empty) begin
        underflow <= 1'b1;
      end
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Head entry is always presented; zero when there is nothing to show.
      assign data_out = fifo_empty ? '0 : mem[rd_ptr];
    end else begin : g_std
      logic [DATA_WIDTH-1:0] dout_q;

      // Holds its value on idle cycles and on refused reads.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          dout_q <= '0;
        end else if (clear) begin
          dout_q <= '0;
        end else if (rd_acc) begin
          dout_q <= mem[rd_ptr];
        end
      end

      assign data_out = dout_q;
    end
  endgenerate

endmodule

// File: doc/sync_fifo_ctrl.md
Name: sync_fifo_ctrl

Overview:
Parametrised single-clock FIFO that succeeds the dual-clock async_fifo for same-domain buffering between pipeline stages. It adds:
- a selectable first-word-fall-through (FWFT) read mode;
- parametrised almost-full and almost-empty thresholds;
- an occupancy count output;
- sticky overflow and underflow error flags;
- a synchronous clear.

Data ordering and the full/empty flag semantics match the async_fifo family.

Parameters:
DATA_WIDTH, 32, width of data_in and data_out.
FIFO_DEPTH, 8, number of entries; must be a power of two and at least 2.
FWFT, 0, read mode: 0 = standard, 1 = first-word-fall-through.
AF_THRESH, FIFO_DEPTH-2, fifo_almost_full asserts when count >= AF_THRESH.
AE_THRESH, 2, fifo_almost_empty asserts when count <= AE_THRESH.

Ports:
clk  input  1  single clock; all logic samples on its rising edge.
reset_n  input  1  asynchronous, active-low reset.
clear  input  1  synchronous flush; active high.
wr_en  input  1  write request.
data_in  input  DATA_WIDTH  write data.
rd_en  input  1  read request (pop).
data_out  output  DATA_WIDTH  read data.
fifo_full  output  1  count == FIFO_DEPTH.
fifo_empty  output  1  count == 0.
fifo_almost_full  output  1  count >= AF_THRESH.
fifo_almost_empty  output  1  count <= AE_THRESH.
fill_count  output  $clog2(FIFO_DEPTH)+1  current occupancy, 0..FIFO_DEPTH.
overflow  output  1  sticky; a write was attempted while full.
underflow  output  1  sticky; a read was attempted while empty.

Behaviour:
- Reset (reset_n low, asynchronous, any time including mid-burst):
  - read pointer, write pointer and count go to 0;
  - data_out=0, overflow=0, underflow=0, fifo_empty=1, fifo_full=0, fifo_almost_empty=1, fifo_almost_full=0;
  - memory contents are don't-care.
- Pointers: $clog2(FIFO_DEPTH) bits; they wrap from FIFO_DEPTH-1 to 0 with no gap.
- Write acceptance: a write is accepted iff wr_en=1 and fifo_full=0 at the clock edge. The accepted write stores data_in at the write pointer, then increments the pointer.
- Read acceptance: a read is accepted iff rd_en=1 and fifo_empty=0 at the clock edge; the accepted read increments the read pointer.
- Simultaneous accepted read and write: count is unchanged and both pointers advance.
  - Full with wr_en and rd_en both high: the read is accepted, the write is rejected and overflow is set.
  - Empty with both high: the write is accepted, the read is rejected and underflow is set.
- Count and flags: fill_count is registered. All four flags are decoded combinationally from fill_count, so they reflect an accepted operation one edge after it.
- Standard mode (FWFT=0):
  - data_out is a register loaded with the head entry on the edge that accepts a read, giving 1-cycle read latency;
  - it holds its value otherwise, including when a read is rejected.
- FWFT mode (FWFT=1):
  - data_out is the head entry whenever fifo_empty=0, and 0 when empty;
  - an accepted read removes the shown word; the next entry appears after that edge;
  - a write into an empty FIFO is visible on data_out after the write edge.
- Error flags: overflow and underflow are sticky until clear or reset; their setting does not alter the FIFO contents.
- Clear (clear=1 at an edge):
  - pointers and count go to 0, data_out=0, overflow=0, underflow=0;
  - clear overrides wr_en and rd_en in the same cycle, so no write is stored.
- Thresholds: values outside 0..FIFO_DEPTH are illegal. The block must flag them with an elaboration-time $error.

Test Plan:
1. Reset with defaults (FWFT=0): drive reset_n=0 for 2 cycles, then release. Required: fifo_empty=1, fifo_almost_empty=1, fill_count=0, data_out=0, overflow=0, underflow=0.
2. Fill and drain:
   - write 8 random values (1..64) on consecutive cycles. Required: fifo_almost_full=1 when fill_count=6; fifo_full=1 after the 8th write.
   - Then 8 reads. Required: data_out matches each write in order, each 1 cycle after its rd_en edge; fifo_empty=1 at the end.
3. Error flags:
   - when full, pulse wr_en with data_in=99. Required: overflow=1, fill_count stays 8, 99 is never read out.
   - After draining, pulse rd_en. Required: underflow=1. Both flags stay set until clear=1 for one cycle, after which both are 0.
4. Wrap-around and concurrency: write 5 entries, read 3, then hold wr_en=rd_en=1 for 10 cycles with an incrementing data_in. Required: fill_count stays 2 throughout and the output stream is strictly in order across the pointer wrap.
5. FWFT=1: write 0x11 into the empty FIFO. Required: data_out=0x11 on the next cycle with no rd_en. Write 0x22, then read once. Required: data_out becomes 0x22.
6. Reset mid-burst: drop reset_n asynchronously (off-edge) while at fill_count=5 and wr_en=1. Required: fill_count=0, fifo_empty=1 and data_out=0 immediately, without a clock edge. After release, a write then a read returns the new value.
